// File: rtl/hazard_light_sched_pkg.sv
// hazard_pkg: shared types and helpers for the hazard-light scheduler.
//   mode_t        : sequencer mode-select encoding
//   state_t       : scheduler FSM states
//   mode_len()    : steps in one pattern for a given mode
//   grant_to_mode(): decode of a one-hot grant into the sequencer select
//   idx_after()   : round-robin index following a one-hot owner
package hazard_pkg;

  typedef enum logic [1:0] {
    MODE_CENTER = 2'b00,
    MODE_UP     = 2'b01,
    MODE_DOWN   = 2'b10,
    MODE_OFF    = 2'b11
  } mode_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [1:0] LEN_CENTER = 2'd2;
  localparam logic [1:0] LEN_SWEEP  = 2'd3;

  // Pattern length; OFF never runs a pattern, so it reports a single step.
  function automatic logic [1:0] mode_len(input mode_t m);
    case (m)
      MODE_CENTER:      mode_len = LEN_CENTER;
      MODE_UP,
      MODE_DOWN:        mode_len = LEN_SWEEP;
      default:          mode_len = 2'd1;
    endcase
  endfunction

  function automatic mode_t grant_to_mode(input logic [2:0] g);
    case (g)
      3'b001:  grant_to_mode = MODE_CENTER;
      3'b010:  grant_to_mode = MODE_UP;
      3'b100:  grant_to_mode = MODE_DOWN;
      default: grant_to_mode = MODE_OFF;
    endcase
  endfunction

  // Position after the owner in round-robin order (wraps 2 -> 0).
  function automatic logic [1:0] idx_after(input logic [2:0] g);
    case (g)
      3'b001:  idx_after = 2'd1;
      3'b010:  idx_after = 2'd2;
      3'b100:  idx_after = 2'd0;
      default: idx_after = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/hazard_light_sched_rr_pick3.sv
// rr_pick3: combinational round-robin picker for three requesters.
//   i_req   [2:0] : request bits
//   i_start [1:0] : first index to consider (0..2)
//   o_pick  [2:0] : one-hot first asserted request at or after i_start, 000 if none
module rr_pick3
  import hazard_pkg::*;
(
  input  logic [2:0] i_req,
  input  logic [1:0] i_start,
  output logic [2:0] o_pick
);

  // Fixed priority chain rotated by the start index.
  always_comb begin
    o_pick = 3'b000;
    case (i_start)
      2'd0: begin
        if      (i_req[0]) o_pick = 3'b001;
        else if (i_req[1]) o_pick = 3'b010;
        else if (i_req[2]) o_pick = 3'b100;
        else               o_pick = 3'b000;
      end
      2'd1: begin
        if      (i_req[1]) o_pick = 3'b010;
        else if (i_req[2]) o_pick = 3'b100;
        else if (i_req[0]) o_pick = 3'b001;
        else               o_pick = 3'b000;
      end
      2'd2: begin
        if      (i_req[2]) o_pick = 3'b100;
        else if (i_req[0]) o_pick = 3'b001;
        else if (i_req[1]) o_pick = 3'b010;
        else               o_pick = 3'b000;
      end
      default: o_pick = 3'b000;
    endcase
  end

endmodule

// File: rtl/hazard_light_sched.sv
// hazard_light_sched: round-robin owner scheduling for one shared
// three-lamp hazard-light sequencer. Grants change only at pattern
// boundaries; an owner keeps the sequencer for at least HOLD patterns
// while others wait.
//   HOLD        : minimum whole patterns per grant when contended (>= 1)
//   clk         : rising-edge clock
//   reset_n     : asynchronous active-low reset
//   req   [2:0] : level requests (0 center, 1 sweep-up, 2 sweep-down)
//   mode  [1:0] : sequencer select, registered decode of grant
//   grant [2:0] : one-hot owner, 000 when idle
//   phase [1:0] : step within the current pattern
//   busy        : high while a pattern is running
module hazard_light_sched
  import hazard_pkg::*;
#(
  parameter int HOLD = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] req,
  output logic [1:0] mode,
  output logic [2:0] grant,
  output logic [1:0] phase,
  output logic       busy
);

  localparam int             CW     = (HOLD < 1) ? 1 : $clog2(HOLD + 1);
  localparam logic [CW-1:0]  HOLD_C = CW'(HOLD);

  state_t        r_state;
  mode_t         r_mode;
  logic [2:0]    r_grant;
  logic [1:0]    r_phase;
  logic [1:0]    r_ptr;
  logic [CW-1:0] r_cnt;
  logic          r_busy;

  logic [2:0]    w_idle_pick;
  logic [2:0]    w_other_pick;
  logic [2:0]    w_req_others;
  logic [1:0]    w_after_owner;
  logic [1:0]    w_len;
  logic          w_boundary;
  logic          w_owner_req;
  logic [CW-1:0] w_cnt_next;
  logic          w_handover;
  logic          w_release;

  assign w_req_others  = req & ~r_grant;
  assign w_after_owner = idx_after(r_grant);

  // Winner when starting from IDLE: scan from the RR pointer.
  rr_pick3 u_pick_idle (
    .i_req   (req),
    .i_start (r_ptr),
    .o_pick  (w_idle_pick)
  );

  // Successor candidate at a boundary: scan from just after the owner,
  // excluding the owner itself.
  rr_pick3 u_pick_next (
    .i_req   (w_req_others),
    .i_start (w_after_owner),
    .o_pick  (w_other_pick)
  );

  // Boundary detection and the yield/continue/release decision.
  always_comb begin
    w_len       = mode_len(r_mode);
    w_boundary  = (r_state == ST_RUN) && (r_phase == (w_len - 2'd1));
    w_owner_req = |(req & r_grant);
    // Count including the pattern that ends at this boundary, saturating.
    if (r_cnt >= HOLD_C) begin
      w_cnt_next = HOLD_C;
    end else begin
      w_cnt_next = r_cnt + CW'(1);
    end
    w_handover = 1'b0;
    w_release  = 1'b0;
    if (!w_owner_req) begin
      w_handover = |w_other_pick;
      w_release  = ~|w_other_pick;
    end else if ((w_cnt_next >= HOLD_C) && (|w_other_pick)) begin
      w_handover = 1'b1;
      w_release  = 1'b0;
    end else begin
      w_handover = 1'b0;
      w_release  = 1'b0;
    end
  end

  // Scheduler FSM with phase/pattern counters and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_mode  <= MODE_OFF;
      r_grant <= 3'b000;
      r_phase <= 2'd0;
      r_ptr   <= 2'd0;
      r_cnt   <= {CW{1'b0}};
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // Sequencer is held at its first step while idle.
          r_phase <= 2'd0;
          r_cnt   <= {CW{1'b0}};
          if (|req) begin
            r_state <= ST_RUN;
            r_grant <= w_idle_pick;
            r_mode  <= grant_to_mode(w_idle_pick);
            r_ptr   <= idx_after(w_idle_pick);
            r_busy  <= 1'b1;
          end else begin
            r_grant <= 3'b000;
            r_mode  <= MODE_OFF;
            r_busy  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (!w_boundary) begin
            r_phase <= r_phase + 2'd1;
          end else begin
            r_phase <= 2'd0;
            if (w_handover) begin
              r_grant <= w_other_pick;
              r_mode  <= grant_to_mode(w_other_pick);
              r_ptr   <= idx_after(w_other_pick);
              r_cnt   <= {CW{1'b0}};
            end else if (w_release) begin
              r_state <= ST_IDLE;
              r_grant <= 3'b000;
              r_mode  <= MODE_OFF;
              r_busy  <= 1'b0;
              r_cnt   <= {CW{1'b0}};
            end else begin
              r_cnt   <= w_cnt_next;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_mode  <= MODE_OFF;
          r_grant <= 3'b000;
          r_phase <= 2'd0;
          r_cnt   <= {CW{1'b0}};
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign mode  = r_mode;
  assign grant = r_grant;
  assign phase = r_phase;
  assign busy  = r_busy;

endmodule

// File: tb/tb_hazard_light_sched.sv
// Bench for hazard_light_sched: two instances (HOLD=2 and HOLD=1) share
// one request stream and are compared every cycle with a per-instance
// behavioural model of owners, pattern lengths and round-robin order.
module tb_hazard_light_sched;

  logic       clk;
  logic       reset_n;
  logic [2:0] req;
  logic [1:0] mode0, mode1;
  logic [2:0] grant0, grant1;
  logic [1:0] phase0, phase1;
  logic       busy0, busy1;

  int n_total = 0;
  int n_bad   = 0;

  // Model state per instance: owner index (-1 idle), step, finished
  // patterns, next RR start.
  int m_own  [2];
  int m_ph   [2];
  int m_cnt  [2];
  int m_ptr  [2];
  int m_hold [2] = '{2, 1};

  int rot_cnt = 0;
  bit rot_en  = 1'b0;

  hazard_light_sched #(.HOLD(2)) u_dut_h2 (
    .clk(clk), .reset_n(reset_n), .req(req),
    .mode(mode0), .grant(grant0), .phase(phase0), .busy(busy0)
  );

  hazard_light_sched #(.HOLD(1)) u_dut_h1 (
    .clk(clk), .reset_n(reset_n), .req(req),
    .mode(mode1), .grant(grant1), .phase(phase1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int first_from(input logic [2:0] r, input int start, input int skip);
    for (int i = 0; i < 3; i++) begin
      int j;
      j = (start + i) % 3;
      if (j != skip && r[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_own[k] = -1; m_ph[k] = 0; m_cnt[k] = 0; m_ptr[k] = 0;
    end
  endtask

  task automatic model_grant(input int k, input int who);
    m_own[k] = who; m_ph[k] = 0; m_cnt[k] = 0; m_ptr[k] = (who + 1) % 3;
  endtask

  task automatic model_step(input int k, input logic [2:0] r);
    int len, n, nxt;
    if (m_own[k] < 0) begin
      nxt = first_from(r, m_ptr[k], -1);
      if (nxt >= 0) model_grant(k, nxt);
    end else begin
      len = (m_own[k] == 0) ? 2 : 3;
      if (m_ph[k] < len - 1) begin
        m_ph[k]++;
      end else begin
        m_ph[k] = 0;
        n   = (m_cnt[k] + 1 > m_hold[k]) ? m_hold[k] : m_cnt[k] + 1;
        nxt = first_from(r, m_own[k] + 1, m_own[k]);
        if (!r[m_own[k]]) begin
          if (nxt >= 0) model_grant(k, nxt);
          else m_own[k] = -1;
        end else if (n >= m_hold[k] && nxt >= 0) begin
          model_grant(k, nxt);
        end else begin
          m_cnt[k] = n;
        end
      end
    end
  endtask

  // Expected {busy, phase, mode, grant}.
  function automatic logic [7:0] model_vec(input int k);
    logic [2:0] g;
    logic [1:0] md;
    logic [1:0] ph;
    if (m_own[k] < 0) return 8'h18;
    g  = 3'b001 << m_own[k];
    md = 2'(m_own[k]);
    ph = 2'(m_ph[k]);
    return {1'b1, ph, md, g};
  endfunction

  // One clock: compare at the falling edge, drive req, update model at the rising edge.
  task automatic cycle(input logic [2:0] r);
    @(negedge clk);
    check_eq("hold2", {busy0, phase0, mode0, grant0}, model_vec(0));
    check_eq("hold1", {busy1, phase1, mode1, grant1}, model_vec(1));
    if (rot_en && mode0 == 2'b01) rot_cnt++;
    req = r;
    @(posedge clk);
    if (!reset_n) model_reset();
    else begin
      model_step(0, r);
      model_step(1, r);
    end
  endtask

  task automatic async_reset_check();
    #3 reset_n = 1'b0;
    #1;
    check_eq("async_rst_h2", {busy0, phase0, mode0, grant0}, 8'h18);
    check_eq("async_rst_h1", {busy1, phase1, mode1, grant1}, 8'h18);
    model_reset();
  endtask

  initial begin
    logic [2:0] r;
    int rst_left;
    reset_n = 1'b0;
    req     = 3'b111;
    model_reset();
    for (int i = 0; i < 4; i++) cycle(3'b111);
    #2 reset_n = 1'b1;

    // Rotation: sweep-up owner, sweep-down joins at phase 1.
    rot_en = 1'b1;
    cycle(3'b010);
    cycle(3'b010);
    cycle(3'b110);
    for (int i = 0; i < 10; i++) cycle(3'b110);
    rot_en = 1'b0;
    check_eq("rot_up_cycles", 32'(rot_cnt), 32'd6);

    // Release to idle, then a single center owner.
    for (int i = 0; i < 8; i++) cycle(3'b000);
    for (int i = 0; i < 8; i++) cycle(3'b001);
    // Drop the center request mid-pattern.
    for (int i = 0; i < 6; i++) cycle(3'b000);
    cycle(3'b001);
    cycle(3'b001);
    for (int i = 0; i < 5; i++) cycle(3'b000);

    // Full contention.
    for (int i = 0; i < 30; i++) cycle(3'b111);

    // Reset in the middle of a sweep, then restart with sweep-up.
    async_reset_check();
    cycle(3'b010);
    #2 reset_n = 1'b1;
    for (int i = 0; i < 6; i++) cycle(3'b010);

    // Randomized traffic with occasional asynchronous resets.
    r = 3'b000;
    rst_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) r = 3'($urandom_range(0, 7));
      cycle(r);
      if (rst_left > 0) begin
        rst_left--;
        if (rst_left == 0) #2 reset_n = 1'b1;
      end else if ($urandom_range(0, 199) == 0) begin
        async_reset_check();
        rst_left = $urandom_range(1, 3);
      end
    end
    if (!reset_n) #2 reset_n = 1'b1;
    for (int i = 0; i < 4; i++) cycle(3'b000);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
